pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core. It turns per-stage stall requests into the 6-bit `stall` vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It sequences multi-cycle EX operations (div, madd/msub) with its own cycle counter. It also converts a committed exception into a one-cycle pipeline flush plus a redirect PC.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_mc_counter.sv | 38 +++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller:
// stall row encodings, FSM states, reset level and the vector address helper.
package pipe_ctrl_pkg;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b0;  // reset is active-low

  // Stall rows: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MC    = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Each exception cause owns an 8-byte slot in the vector table.
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [4:0] code);
    return base + {24'd0, code, 3'b000};
  endfunction

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Multi-cycle op counter: load len-1, count down to 1, hold at 1 while the
// done cycle is stretched, then drop to 0. Busy/done are decoded from the count.
module mc_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_clear,
  input  logic         i_hold,
  output logic         o_busy,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Count register: clear beats load, load beats decrement/hold/retire.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt > W'(1)) begin
      r_cnt <= r_cnt - W'(1);
    end else if ((r_cnt == W'(1)) && !i_hold) begin
      r_cnt <= '0;
    end
  end

  assign o_busy = (r_cnt > W'(1));
  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector, multi-cycle EX sequencing and
// exception flush/redirect. Optional PC-stall cycle counter is built when
// PIPE_CTRL_STALL_CNT_EN is defined; otherwise stall_cycles is tied to 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0020,
  parameter int          MC_LEN_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                ex_mc_start,
  input  logic [MC_LEN_W-1:0] ex_mc_len,
  input  logic                excp_valid,
  input  logic [4:0]          excp_code,
  output logic [5:0]          stall,
  output logic                ex_mc_done,
  output logic                ex_mc_abort,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic [31:0]         stall_cycles,
  input  logic                cnt_clr
);

  state_t r_state;
  state_t w_state_next;
  logic   w_take_excp;
  logic   w_mc_load;
  logic   w_mc_clear;
  logic   w_mc_stall;
  logic   w_cnt_busy;
  logic   w_cnt_done;
  logic   w_len_multi;
  logic   r_flush;
  logic   r_abort;
  logic [31:0] r_new_pc;

  assign w_len_multi = (ex_mc_len >= MC_LEN_W'(2));

  mc_counter #(.W(MC_LEN_W)) u_mc_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_mc_load),
    .i_load_val (ex_mc_len - MC_LEN_W'(1)),
    .i_clear    (w_mc_clear),
    .i_hold     (stallreq_mem),
    .o_busy     (w_cnt_busy),
    .o_done     (w_cnt_done)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) r_state <= ST_RUN;
    else                   r_state <= w_state_next;
  end

  // Next-state logic plus counter control and the internal EX stall.
  always_comb begin
    w_state_next = r_state;
    w_take_excp  = 1'b0;
    w_mc_load    = 1'b0;
    w_mc_clear   = 1'b0;
    w_mc_stall   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (excp_valid) begin
          w_state_next = ST_FLUSH;
          w_take_excp  = 1'b1;
        end else if (ex_mc_start && w_len_multi) begin
          w_state_next = ST_MC;
          w_mc_load    = 1'b1;
          w_mc_stall   = 1'b1;
        end
      end
      ST_MC: begin
        w_mc_stall = w_cnt_busy;
        if (excp_valid) begin
          w_state_next = ST_FLUSH;
          w_take_excp  = 1'b1;
          w_mc_clear   = 1'b1;
        end else if (w_cnt_done && !stallreq_mem) begin
          w_state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Exceptions seen here belong to already-flushed instructions.
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Stall vector priority: flush/exception, MEM, EX, ID, IF.
  always_comb begin
    stall = STALL_NONE;
    if ((r_state == ST_FLUSH) || excp_valid) stall = STALL_NONE;
    else if (stallreq_mem)                   stall = STALL_MEM;
    else if (stallreq_ex || w_mc_stall)      stall = STALL_EX;
    else if (stallreq_id)                    stall = STALL_ID;
    else if (stallreq_if)                    stall = STALL_IF;
  end

  // Registered flush, redirect target and abort pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_flush  <= 1'b0;
      r_abort  <= 1'b0;
      r_new_pc <= 32'd0;
    end else begin
      r_flush  <= w_take_excp;
      r_abort  <= w_take_excp && (r_state == ST_MC);
      r_new_pc <= w_take_excp ? vec_addr(VEC_BASE, excp_code) : 32'd0;
    end
  end

  assign flush       = r_flush;
  assign ex_mc_abort = r_abort;
  assign new_pc      = r_new_pc;
  // An exception in the done cycle kills the result.
  assign ex_mc_done  = (r_state == ST_MC) && w_cnt_done && !excp_valid;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of cycles with the PC held; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_stall_cycles <= 32'd0;
    end else if (cnt_clr) begin
      r_stall_cycles <= 32'd0;
    end else if ((stall[0] == STOP) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign stall_cycles     = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and random stimulus for pipe_ctrl against a cycle-timeline model.
module tb_pipe_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if = 0, stallreq_id = 0, stallreq_ex = 0, stallreq_mem = 0;
  logic        ex_mc_start = 0;
  logic [5:0]  ex_mc_len = '0;
  logic        excp_valid = 0;
  logic [4:0]  excp_code = '0;
  logic        cnt_clr = 0;
  logic [5:0]  stall;
  logic        ex_mc_done, ex_mc_abort, flush;
  logic [31:0] new_pc, stall_cycles;

  pipe_ctrl #(.VEC_BASE(VEC), .MC_LEN_W(6)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len),
    .excp_valid(excp_valid), .excp_code(excp_code),
    .stall(stall), .ex_mc_done(ex_mc_done), .ex_mc_abort(ex_mc_abort),
    .flush(flush), .new_pc(new_pc), .stall_cycles(stall_cycles),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Model: an op in flight finishes at absolute cycle m_done_cyc.
  bit          m_busy, m_flush, m_abort;
  int          m_done_cyc, m_cyc;
  logic [31:0] m_newpc, m_sc;
  logic [5:0]  m_stall_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_flush = 0; m_abort = 0; m_done_cyc = 0;
    m_newpc = 0; m_sc = 0; m_cyc = 0;
  endtask

  task automatic drive(input bit s_if, input bit s_id, input bit s_ex, input bit s_mem,
                       input bit start, input int len, input bit excp, input int code,
                       input bit clr);
    stallreq_if = s_if; stallreq_id = s_id; stallreq_ex = s_ex; stallreq_mem = s_mem;
    ex_mc_start = start; ex_mc_len = 6'(len);
    excp_valid = excp; excp_code = 5'(code); cnt_clr = clr;
  endtask

  // Mid-cycle: compare every output with the model.
  task automatic eval();
    bit mc_stall, exp_done;
    @(negedge clk);
    mc_stall = (!m_flush && !m_busy && ex_mc_start && (ex_mc_len >= 2)) ||
               (m_busy && (m_cyc < m_done_cyc));
    exp_done = m_busy && (m_cyc >= m_done_cyc) && !excp_valid;
    if (m_flush || excp_valid)      m_stall_exp = 6'b000000;
    else if (stallreq_mem)          m_stall_exp = 6'b011111;
    else if (stallreq_ex || mc_stall) m_stall_exp = 6'b001111;
    else if (stallreq_id)           m_stall_exp = 6'b000111;
    else if (stallreq_if)           m_stall_exp = 6'b000011;
    else                            m_stall_exp = 6'b000000;
    chk("stall", 32'(stall), 32'(m_stall_exp));
    chk("done", 32'(ex_mc_done), 32'(exp_done));
    chk("abort", 32'(ex_mc_abort), 32'(m_abort));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("new_pc", new_pc, m_newpc);
    chk("stall_cycles", stall_cycles, m_sc);
  endtask

  // Clock edge: advance the model with the inputs the DUT just sampled.
  task automatic adv();
    bit nf, nab;
    @(posedge clk);
    nf  = !m_flush && excp_valid;
    nab = !m_flush && excp_valid && m_busy;
    if (m_flush || excp_valid) begin
      m_busy = 0;
    end else if (m_busy) begin
      if ((m_cyc >= m_done_cyc) && !stallreq_mem) m_busy = 0;
    end else if (ex_mc_start && (ex_mc_len >= 2)) begin
      m_busy = 1;
      m_done_cyc = m_cyc + int'(ex_mc_len) - 1;
    end
`ifdef PIPE_CTRL_STALL_CNT_EN
    if (cnt_clr) m_sc = 0;
    else if (m_stall_exp[0] && (m_sc != 32'hFFFF_FFFF)) m_sc = m_sc + 1;
`endif
    m_flush = nf;
    m_abort = nab;
    m_newpc = nf ? (VEC + (32'(excp_code) << 3)) : 32'd0;
    m_cyc++;
    #1;
  endtask

  task automatic cycle();
    eval();
    adv();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(ex_mc_done), 32'd0);
    chk("rst_abort", 32'(ex_mc_abort), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    idle(); cycle();

    // Load-use stall alone, then with MEM wait on top
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); eval(); chk("tp_id", 32'(stall), 32'h07); adv();
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0); eval(); chk("tp_id_mem", 32'(stall), 32'h1f); adv();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); eval(); chk("tp_if", 32'(stall), 32'h03); adv();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); eval(); chk("tp_ex", 32'(stall), 32'h0f); adv();

    // len=4 op: stall T..T+2, done at T+3
    drive(0, 0, 0, 0, 1, 4, 0, 0, 0); eval(); chk("mc4_T", 32'(stall), 32'h0f); adv();
    idle(); cycle(); cycle();
    eval(); chk("mc4_done", 32'(ex_mc_done), 32'd1); chk("mc4_nostall", 32'(stall), 32'd0); adv();
    cycle();

    // len=4 with MEM wait in the done cycle: done stretched to T+4, RUN at T+5
    drive(0, 0, 0, 0, 1, 4, 0, 0, 0); cycle();
    idle(); cycle(); cycle();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0); eval(); chk("mc4m_done3", 32'(ex_mc_done), 32'd1); adv();
    idle(); eval(); chk("mc4m_done4", 32'(ex_mc_done), 32'd1); adv();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0); eval(); chk("mc4m_run", 32'(ex_mc_done), 32'd0); adv();

    // len=1 and len=0 ops never stall
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0); eval(); chk("mc1_nostall", 32'(stall), 32'd0); adv();
    idle(); cycle();

    // Exception at T+1 of a len=8 op
    drive(0, 0, 0, 0, 1, 8, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 3, 0); cycle();
    idle(); eval();
    chk("ex_abort", 32'(ex_mc_abort), 32'd1);
    chk("ex_flush", 32'(flush), 32'd1);
    chk("ex_new_pc", new_pc, 32'h38);
    adv();
    repeat (8) cycle();

    // Two back-to-back exceptions give one flush
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0); eval(); chk("dbl_flush1", 32'(flush), 32'd1); adv();
    idle(); eval(); chk("dbl_flush2", 32'(flush), 32'd0); adv();

    // PC-stall counter: clear, 10 IF stalls, then clear again
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); repeat (10) cycle();
    idle(); eval();
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk("cnt10", stall_cycles, 32'd10);
`else
    chk("cnt_off", stall_cycles, 32'd0);
`endif
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    idle(); eval(); chk("cnt_clr", stall_cycles, 32'd0); adv();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 9)),
            ($urandom_range(0, 19) == 0), int'($urandom_range(0, 31)),
            ($urandom_range(0, 15) == 0));
      cycle();
    end

    // Asynchronous reset in the middle of a multi-cycle op
    idle();
    drive(1, 0, 0, 0, 1, 10, 0, 0, 0); cycle();
    idle(); cycle(); cycle();
    #2 rst = 1'b0;
    #1;
    chk("amid_stall", 32'(stall), 32'd0);
    chk("amid_done", 32'(ex_mc_done), 32'd0);
    chk("amid_abort", 32'(ex_mc_abort), 32'd0);
    chk("amid_flush", 32'(flush), 32'd0);
    chk("amid_new_pc", new_pc, 32'd0);
    chk("amid_stall_cycles", stall_cycles, 32'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    repeat (12) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
